// File: rtl/intr_pkg.sv
// intr_pkg: shared types and helpers for the interrupt controller.
// Holds the FSM state encoding, the supported line-count limit and the
// lowest-index-wins priority encoder used to pick the next interrupt.
package intr_pkg;

  localparam int STATE_W = 2;
  localparam int MAX_IRQ = 8;
  localparam int SEL_W   = $clog2(MAX_IRQ);

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Returns the index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_sync.sv
// intr_sync: three-flop synchroniser for one asynchronous interrupt line.
// The first two flops resolve metastability; the third gives the previous
// synchronised value so a single-cycle rising-edge pulse can be produced.
module intr_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-triggered interrupt controller feeding the core's single
// request input. Lines are synchronised, latched as sticky pending bits,
// masked, prioritised (lowest index wins) and handed to the core through a
// request / acknowledge / done handshake, one interrupt in service at a time.
// Optional feature: define INTR_LOST_EN to add lost_q / lost_clr, which flag
// edges that arrived while the same line was already pending.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int                 NUM_IRQ  = 4,
  parameter int                 ID_W     = $clog2(NUM_IRQ),
  parameter logic [NUM_IRQ-1:0] MASK_RST = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask_q,
  output logic [NUM_IRQ-1:0] pending_q,
  output logic               int_sig,
  output logic [ID_W-1:0]    int_id,
  input  logic               int_ack,
  input  logic               int_done,
`ifdef INTR_LOST_EN
  input  logic [NUM_IRQ-1:0] lost_clr,
  output logic [NUM_IRQ-1:0] lost_q,
`endif
  output logic               busy
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    id_nxt;
  logic               ack_take;
  state_t             state;
  state_t             state_nxt;

  genvar g;
  for (g = 0; g < NUM_IRQ; g++) begin : g_sync
    intr_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (irq_in[g]),
      .rise     (rise[g])
    );
  end

  assign eligible = pending_q & mask_q;
  assign sel      = ID_W'(lowest_set(MAX_IRQ'(eligible)));
  assign ack_take = (state == REQ) && int_ack;

  // Decode the acknowledged line into a one-hot pending clear.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = ack_take && (int_id == ID_W'(i));
    end
  end

  // Sticky pending bits (a new edge beats a same-cycle clear) and the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      pending_q <= rise | (pending_q & ~clr);
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  // Handshake state register and the latched id of the requested line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      int_id <= '0;
    end else begin
      state  <= state_nxt;
      int_id <= id_nxt;
    end
  end

  // Next-state logic; the id is only retargeted when leaving IDLE.
  always_comb begin
    state_nxt = state;
    id_nxt    = int_id;
    case (state)
      IDLE: begin
        if (eligible != '0) begin
          state_nxt = REQ;
          id_nxt    = sel;
        end
      end
      REQ: begin
        if (int_ack) state_nxt = SERVICE;
      end
      SERVICE: begin
        if (int_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign int_sig = (state == REQ);
  assign busy    = (state == REQ) || (state == SERVICE);

`ifdef INTR_LOST_EN
  logic [NUM_IRQ-1:0] lost_set;

  assign lost_set = rise & pending_q & ~clr;

  // Record coalesced edges; a new loss beats a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      lost_q <= '0;
    end else begin
      lost_q <= (lost_q & ~lost_clr) | lost_set;
    end
  end
`endif

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: scoreboard bench for intr_ctrl. Expected request ids are
// queued as stimulus is issued; a monitor pops and compares them whenever
// the controller raises a new request. Build with INTR_LOST_EN to also
// exercise the lost-edge flags.
module tb_intr_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq_in;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [N-1:0] mask_q;
  logic [N-1:0] pending_q;
  logic         int_sig;
  logic [1:0]   int_id;
  logic         int_ack;
  logic         int_done;
  logic         busy;
`ifdef INTR_LOST_EN
  logic [N-1:0] lost_clr;
  logic [N-1:0] lost_q;
`endif

  int unsigned expQ[$];
  int          nChecks = 0;
  int          nPass   = 0;
  logic [N-1:0] pendM;
  logic [N-1:0] maskM;

  intr_ctrl #(.NUM_IRQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pending_q  (pending_q),
    .int_sig    (int_sig),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .int_done   (int_done),
`ifdef INTR_LOST_EN
    .lost_clr   (lost_clr),
    .lost_q     (lost_q),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference priority rule: lowest set index of a vector.
  function automatic int lowestOf(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic waitReq();
    int n;
    n = 0;
    while (!int_sig && n < 50) begin
      tick();
      n++;
    end
    checkOutput("req_seen", 32'(int_sig), 32'd1);
  endtask

  task automatic doAck(input logic [N-1:0] expPend);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checkOutput("ack_sig", 32'(int_sig), 32'd0);
    checkOutput("ack_busy", 32'(busy), 32'd1);
    checkOutput("ack_pend", 32'(pending_q), 32'(expPend));
  endtask

  task automatic doDone();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_sig", 32'(int_sig), 32'd0);
  endtask

  task automatic serviceOne(input logic [N-1:0] expPend);
    waitReq();
    if (int_sig) begin
      doAck(expPend);
      doDone();
    end
  endtask

  task automatic pulseIrq(input logic [N-1:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
  endtask

  // Monitor: every new request must match the oldest queued expectation.
  initial begin : monitor
    logic prevSig;
    int unsigned expId;
    prevSig = 1'b0;
    forever begin
      @(negedge clk);
      if (int_sig && !prevSig) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_req", 32'(int_id), 32'hFFFF_FFFF);
        end else begin
          expId = expQ.pop_front();
          checkOutput("req_id", 32'(int_id), expId);
        end
      end
      prevSig = int_sig;
    end
  end

  task automatic applyStimulus();
    int id;
    logic [N-1:0] e;
    logic [N-1:0] m;
    logic doMask;

    // Reset with every line already high.
    rst = 1'b1; irq_in = 4'hF; mask_we = 1'b0; mask_wdata = '0;
    int_ack = 1'b0; int_done = 1'b0;
`ifdef INTR_LOST_EN
    lost_clr = '0;
`endif
    tick();
    tick();
    checkOutput("rst_sig", 32'(int_sig), 32'd0);
    checkOutput("rst_mask", 32'(mask_q), 32'hF);
    checkOutput("rst_pend", 32'(pending_q), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_id", 32'(int_id), 32'd0);
`ifdef INTR_LOST_EN
    checkOutput("rst_lost", 32'(lost_q), 32'd0);
`endif
    expQ.push_back(0); expQ.push_back(1); expQ.push_back(2); expQ.push_back(3);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("rel_pend_e1", 32'(pending_q), 32'd0);
    tick();
    checkOutput("rel_pend_e2", 32'(pending_q), 32'hF);
    checkOutput("rel_sig_e2", 32'(int_sig), 32'd0);
    tick();
    checkOutput("rel_sig_e3", 32'(int_sig), 32'd1);
    checkOutput("rel_id_e3", 32'(int_id), 32'd0);
    serviceOne(4'b1110);
    serviceOne(4'b1100);
    serviceOne(4'b1000);
    serviceOne(4'b0000);
    irq_in = '0;
    repeat (4) tick();

    // Single line latency.
    expQ.push_back(2);
    pulseIrq(4'b0100);
    tick();
    tick();
    checkOutput("single_pend", 32'(pending_q), 32'b0100);
    checkOutput("single_sig_early", 32'(int_sig), 32'd0);
    tick();
    checkOutput("single_sig", 32'(int_sig), 32'd1);
    checkOutput("single_id", 32'(int_id), 32'd2);
    doAck(4'b0000);
    doDone();

    // Simultaneous edges serviced in index order with one idle cycle between.
    expQ.push_back(1); expQ.push_back(3);
    pulseIrq(4'b1010);
    serviceOne(4'b1000);
    tick();
    checkOutput("order_sig", 32'(int_sig), 32'd1);
    checkOutput("order_id", 32'(int_id), 32'd3);
    doAck(4'b0000);
    doDone();

    // Masked pending bit is held and requested once unmasked.
    mask_we = 1'b1; mask_wdata = 4'b1011;
    tick();
    mask_we = 1'b0;
    checkOutput("mask_q", 32'(mask_q), 32'b1011);
    pulseIrq(4'b0100);
    repeat (5) tick();
    checkOutput("mask_pend", 32'(pending_q), 32'b0100);
    checkOutput("mask_sig", 32'(int_sig), 32'd0);
    expQ.push_back(2);
    mask_we = 1'b1; mask_wdata = 4'hF;
    tick();
    mask_we = 1'b0;
    checkOutput("unmask_sig0", 32'(int_sig), 32'd0);
    tick();
    checkOutput("unmask_sig1", 32'(int_sig), 32'd1);
    checkOutput("unmask_id", 32'(int_id), 32'd2);
    doAck(4'b0000);
    doDone();

    // Frozen request, ignored done in REQ and ignored ack in SERVICE.
    expQ.push_back(3); expQ.push_back(0);
    pulseIrq(4'b1000);
    waitReq();
    irq_in = 4'b0001; mask_we = 1'b1; mask_wdata = 4'h0;
    tick();
    irq_in = '0; mask_we = 1'b0;
    repeat (4) tick();
    checkOutput("frozen_sig", 32'(int_sig), 32'd1);
    checkOutput("frozen_id", 32'(int_id), 32'd3);
    checkOutput("frozen_pend", 32'(pending_q), 32'b1001);
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
    checkOutput("done_in_req_sig", 32'(int_sig), 32'd1);
    mask_we = 1'b1; mask_wdata = 4'hF;
    tick();
    mask_we = 1'b0;
    doAck(4'b0001);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checkOutput("ack_in_svc_busy", 32'(busy), 32'd1);
    checkOutput("ack_in_svc_sig", 32'(int_sig), 32'd0);
    checkOutput("ack_in_svc_pend", 32'(pending_q), 32'b0001);
    doDone();
    serviceOne(4'b0000);

`ifdef INTR_LOST_EN
    // Second edge on a still-pending line is flagged, then cleared by software.
    expQ.push_back(1);
    pulseIrq(4'b0010);
    tick();
    tick();
    pulseIrq(4'b0010);
    repeat (4) tick();
    checkOutput("lost_set", 32'(lost_q), 32'b0010);
    lost_clr = 4'b0010;
    tick();
    lost_clr = '0;
    checkOutput("lost_clr", 32'(lost_q), 32'd0);
    doAck(4'b0000);
    doDone();
`endif

    // Randomised rounds against a set-based model of pending and mask.
    pendM = '0;
    maskM = 4'hF;
    for (int r = 0; r < 40; r++) begin
      e      = 4'($urandom_range(0, 15));
      m      = 4'($urandom_range(0, 15));
      doMask = 1'($urandom_range(0, 1));
      pulseIrq(e);
      tick();
      if (doMask) begin
        mask_we = 1'b1;
        mask_wdata = m;
      end
      tick();
      mask_we = 1'b0;
      pendM = pendM | e;
      if (doMask) maskM = m;
      checkOutput("rand_pend", 32'(pending_q), 32'(pendM));
      checkOutput("rand_mask", 32'(mask_q), 32'(maskM));
      while ((pendM & maskM) != '0) begin
        id = lowestOf(pendM & maskM);
        expQ.push_back(id);
        pendM[id] = 1'b0;
        serviceOne(pendM);
      end
    end
    mask_we = 1'b1; mask_wdata = 4'hF;
    tick();
    mask_we = 1'b0;
    maskM = 4'hF;
    while (pendM != '0) begin
      id = lowestOf(pendM);
      expQ.push_back(id);
      pendM[id] = 1'b0;
      serviceOne(pendM);
    end
    repeat (5) tick();
  endtask

  initial begin
    applyStimulus();
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
